// File: rtl/seg_mem1_pkg.sv
// Shared types and constants for the first memory stage: bus payload layouts,
// alusel/aluop codes and a small decode helper.
package seg_mem1_pkg;

  localparam int unsigned PRI_W    = 146;
  localparam int unsigned SEC_W    = 70;
  localparam int unsigned BYP_W    = 76;
  localparam int unsigned ID_W     = 10;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STRB_W   = 4;
  localparam int unsigned SIZE_W   = 2;
  localparam int unsigned ALUOP_W  = 8;
  localparam int unsigned ALUSEL_W = 4;
  localparam int unsigned REGA_W   = 5;

  // Primary bus field offsets (LSB positions)
  localparam int unsigned PRI_INST_ADDR_LSB = 0;
  localparam int unsigned PRI_REG_WRITE_BIT = 32;
  localparam int unsigned PRI_REG_WADDR_LSB = 33;
  localparam int unsigned PRI_REG_WDATA_LSB = 38;
  localparam int unsigned PRI_ALUSEL_LSB    = 70;
  localparam int unsigned PRI_ALUOP_LSB     = 74;
  localparam int unsigned PRI_MEM_ADDR_LSB  = 82;
  localparam int unsigned PRI_OPDATA2_LSB   = 114;

  localparam logic [ALUSEL_W-1:0] ALUSEL_LOAD  = 4'b0111;
  localparam logic [ALUSEL_W-1:0] ALUSEL_STORE = 4'b1000;

  localparam logic [ALUOP_W-1:0] LB_OP  = 8'hE0;
  localparam logic [ALUOP_W-1:0] LH_OP  = 8'hE1;
  localparam logic [ALUOP_W-1:0] LWL_OP = 8'hE2;
  localparam logic [ALUOP_W-1:0] LW_OP  = 8'hE3;
  localparam logic [ALUOP_W-1:0] LBU_OP = 8'hE4;
  localparam logic [ALUOP_W-1:0] LHU_OP = 8'hE5;
  localparam logic [ALUOP_W-1:0] LWR_OP = 8'hE6;
  localparam logic [ALUOP_W-1:0] SB_OP  = 8'hE8;
  localparam logic [ALUOP_W-1:0] SH_OP  = 8'hE9;
  localparam logic [ALUOP_W-1:0] SWL_OP = 8'hEA;
  localparam logic [ALUOP_W-1:0] SW_OP  = 8'hEB;
  localparam logic [ALUOP_W-1:0] SWR_OP = 8'hEE;
  localparam logic [ALUOP_W-1:0] LL_OP  = 8'hF0;
  localparam logic [ALUOP_W-1:0] SC_OP  = 8'hF8;

  typedef struct packed {
    logic [DATA_W-1:0]   opdata2;
    logic [ADDR_W-1:0]   mem_addr;
    logic [ALUOP_W-1:0]  aluop;
    logic [ALUSEL_W-1:0] alusel;
    logic [DATA_W-1:0]   reg_wdata;
    logic [REGA_W-1:0]   reg_waddr;
    logic                reg_write;
    logic [ADDR_W-1:0]   inst_addr;
  } pri_bus_t;

  typedef struct packed {
    logic [DATA_W-1:0] reg_wdata;
    logic [REGA_W-1:0] reg_waddr;
    logic              reg_write;
    logic [ADDR_W-1:0] inst_addr;
  } sec_bus_t;

  // Unaligned-word ops always access the containing aligned word
  function automatic logic is_word_align_op(input logic [ALUOP_W-1:0] op);
    return (op == LWL_OP) || (op == LWR_OP) || (op == SWL_OP) || (op == SWR_OP);
  endfunction

endpackage

// File: rtl/seg_mem1_if.sv
// Data-memory request channel between the memory stage and the data bus.
interface seg_mem1_if;
  import seg_mem1_pkg::*;

  logic              req;
  logic              wr;
  logic [SIZE_W-1:0] size;
  logic [ADDR_W-1:0] addr;
  logic [STRB_W-1:0] wstrb;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;

  modport master (output req, wr, size, addr, wstrb, wdata, input addr_ok);
  modport slave  (input req, wr, size, addr, wstrb, wdata, output addr_ok);
endinterface

// File: rtl/mem1_store_align.sv
// Access size, byte strobes and lane-aligned store data from aluop and address.
module mem1_store_align
  import seg_mem1_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [1:0]         addr_lo,
  input  logic [DATA_W-1:0]  opdata2,
  output logic [SIZE_W-1:0]  size,
  output logic [STRB_W-1:0]  wstrb,
  output logic [DATA_W-1:0]  wdata
);

  // Decode per memory op; loads leave strobes and data at zero
  always_comb begin
    size  = '0;
    wstrb = '0;
    wdata = '0;
    case (aluop)
      LB_OP, LBU_OP: size = 2'd0;
      LH_OP, LHU_OP: size = 2'd1;
      LW_OP, LL_OP, LWL_OP, LWR_OP: size = 2'd2;
      SB_OP: begin
        size  = 2'd0;
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{opdata2[7:0]}};
      end
      SH_OP: begin
        size  = 2'd1;
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{opdata2[15:0]}};
      end
      SW_OP, SC_OP: begin
        size  = 2'd2;
        wstrb = 4'b1111;
        wdata = opdata2;
      end
      SWL_OP: begin
        size = 2'd2;
        case (addr_lo)
          2'd0: begin wstrb = 4'b0001; wdata = {24'b0, opdata2[31:24]}; end
          2'd1: begin wstrb = 4'b0011; wdata = {16'b0, opdata2[31:16]}; end
          2'd2: begin wstrb = 4'b0111; wdata = {8'b0, opdata2[31:8]}; end
          default: begin wstrb = 4'b1111; wdata = opdata2; end
        endcase
      end
      SWR_OP: begin
        size = 2'd2;
        case (addr_lo)
          2'd0: begin wstrb = 4'b1111; wdata = opdata2; end
          2'd1: begin wstrb = 4'b1110; wdata = {opdata2[23:0], 8'b0}; end
          2'd2: begin wstrb = 4'b1100; wdata = {opdata2[15:0], 16'b0}; end
          default: begin wstrb = 4'b1000; wdata = {opdata2[7:0], 24'b0}; end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/seg_mem1.sv
// First memory stage: registers the EX bundle, issues one data request per
// memory op over req/addr_ok, and tracks the LL/SC link bit.
// Optional feature macro: MEM1_LLSC_EN (LLbit register; otherwise SC always succeeds).
module seg_mem1
  import seg_mem1_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mem2_allowin_i,
  input  logic              ex_mem1_valid_i,
  input  logic [PRI_W-1:0]  ex_mem1_bus_primary_i,
  input  logic [SEC_W-1:0]  ex_mem1_bus_secondary_i,
  input  logic              llbit_clear_i,
  seg_mem1_if.master        dmem,
  output logic              mem1_allowin_o,
  output logic              mem1_mem2_valid_o,
  output logic [PRI_W-1:0]  mem1_mem2_bus_primary_o,
  output logic [SEC_W-1:0]  mem1_mem2_bus_secondary_o,
  output logic [BYP_W-1:0]  mem1_bypass_o,
  output logic [ID_W-1:0]   mem1_id_bus_primary_o
);

  logic     valid;
  logic     req_done;
  pri_bus_t pri_q;
  sec_bus_t sec_q;
  pri_bus_t pri_out;

  logic is_store;
  logic is_sc;
  logic llbit_ok;
  logic need_mem;
  logic data_req;
  logic ready_go;
  logic allowin;

  logic [SIZE_W-1:0] al_size;
  logic [STRB_W-1:0] al_wstrb;
  logic [DATA_W-1:0] al_wdata;
  logic [ADDR_W-1:0] req_addr;

  assign is_store = (pri_q.alusel == ALUSEL_STORE);
  assign is_sc    = is_store && (pri_q.aluop == SC_OP);
  assign need_mem = (pri_q.alusel == ALUSEL_LOAD) || (is_store && (!is_sc || llbit_ok));
  assign data_req = valid && need_mem && !req_done;
  assign ready_go = !need_mem || req_done || dmem.addr_ok;
  assign allowin  = !valid || (ready_go && mem2_allowin_i);

`ifdef MEM1_LLSC_EN
  logic llbit;
  logic is_ll;

  assign is_ll    = (pri_q.alusel == ALUSEL_LOAD) && (pri_q.aluop == LL_OP);
  assign llbit_ok = llbit;

  // Link bit: set on LL handshake, cleared by SC leaving or exception; clear wins
  always_ff @(posedge clk) begin
    if (rst) begin
      llbit <= 1'b0;
    end else if (llbit_clear_i || (valid && is_sc && ready_go && mem2_allowin_i)) begin
      llbit <= 1'b0;
    end else if (data_req && dmem.addr_ok && is_ll) begin
      llbit <= 1'b1;
    end
  end
`else
  logic unused_llbit_clear;

  assign llbit_ok           = 1'b1;
  assign unused_llbit_clear = llbit_clear_i;
`endif

  // Stage register; req_done remembers an accepted request while the bundle waits
  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      req_done <= 1'b0;
      pri_q    <= '0;
      sec_q    <= '0;
    end else begin
      if (allowin) begin
        valid <= ex_mem1_valid_i;
      end
      if (allowin && ex_mem1_valid_i) begin
        pri_q    <= pri_bus_t'(ex_mem1_bus_primary_i);
        sec_q    <= sec_bus_t'(ex_mem1_bus_secondary_i);
        req_done <= 1'b0;
      end else if (data_req && dmem.addr_ok) begin
        req_done <= 1'b1;
      end
    end
  end

  mem1_store_align u_align (
    .aluop   (pri_q.aluop),
    .addr_lo (pri_q.mem_addr[1:0]),
    .opdata2 (pri_q.opdata2),
    .size    (al_size),
    .wstrb   (al_wstrb),
    .wdata   (al_wdata)
  );

  assign req_addr = is_word_align_op(pri_q.aluop) ? {pri_q.mem_addr[31:2], 2'b00}
                                                  : pri_q.mem_addr;

  // SC returns its success flag in place of reg_wdata
  always_comb begin
    pri_out = pri_q;
    if (is_sc) begin
      pri_out.reg_wdata = {31'b0, llbit_ok};
    end
  end

  assign dmem.req   = data_req;
  assign dmem.wr    = valid && is_store;
  assign dmem.size  = valid ? al_size  : '0;
  assign dmem.addr  = valid ? req_addr : '0;
  assign dmem.wstrb = valid ? al_wstrb : '0;
  assign dmem.wdata = valid ? al_wdata : '0;

  assign mem1_allowin_o            = allowin;
  assign mem1_mem2_valid_o         = valid && ready_go;
  assign mem1_mem2_bus_primary_o   = valid ? PRI_W'(pri_out) : '0;
  assign mem1_mem2_bus_secondary_o = valid ? SEC_W'(sec_q) : '0;
  assign mem1_bypass_o             = valid ? {sec_q.reg_wdata, sec_q.reg_waddr, sec_q.reg_write,
                                              pri_out.reg_wdata, pri_out.reg_waddr,
                                              pri_out.reg_write} : '0;
  assign mem1_id_bus_primary_o     = valid ? {ready_go, pri_q.reg_waddr, pri_q.alusel} : '0;

endmodule

// File: tb/tb_seg_mem1.sv
// Directed self-checking bench for seg_mem1 (expectations follow MEM1_LLSC_EN).
module tb_seg_mem1;
  import seg_mem1_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             mem2_allowin;
  logic             ex_valid;
  logic [PRI_W-1:0] ex_pri;
  logic [SEC_W-1:0] ex_sec;
  logic             llbit_clear;
  logic             allowin_o;
  logic             valid_o;
  logic [PRI_W-1:0] pri_o;
  logic [SEC_W-1:0] sec_o;
  logic [BYP_W-1:0] byp_o;
  logic [ID_W-1:0]  id_o;

  int checks = 0;
  int errors = 0;

  seg_mem1_if dmem ();

  seg_mem1 dut (
    .clk                       (clk),
    .rst                       (rst),
    .mem2_allowin_i            (mem2_allowin),
    .ex_mem1_valid_i           (ex_valid),
    .ex_mem1_bus_primary_i     (ex_pri),
    .ex_mem1_bus_secondary_i   (ex_sec),
    .llbit_clear_i             (llbit_clear),
    .dmem                      (dmem),
    .mem1_allowin_o            (allowin_o),
    .mem1_mem2_valid_o         (valid_o),
    .mem1_mem2_bus_primary_o   (pri_o),
    .mem1_mem2_bus_secondary_o (sec_o),
    .mem1_bypass_o             (byp_o),
    .mem1_id_bus_primary_o     (id_o)
  );

  always #5 clk = ~clk;

  function automatic logic [PRI_W-1:0] mk_pri(input logic [7:0] op, input logic [3:0] sel,
                                              input logic [31:0] addr, input logic [31:0] od2,
                                              input logic [31:0] rwd, input logic [4:0] wa,
                                              input logic we);
    pri_bus_t p;
    p.opdata2   = od2;
    p.mem_addr  = addr;
    p.aluop     = op;
    p.alusel    = sel;
    p.reg_wdata = rwd;
    p.reg_waddr = wa;
    p.reg_write = we;
    p.inst_addr = 32'hBFC0_0100;
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Back-to-back vectors: op, alusel, addr, opdata2 -> wr, size, req addr, wstrb, wdata
  logic [7:0]  v_op   [6] = '{SWR_OP, SH_OP, SWL_OP, LWR_OP, LH_OP, SB_OP};
  logic [3:0]  v_sel  [6] = '{ALUSEL_STORE, ALUSEL_STORE, ALUSEL_STORE, ALUSEL_LOAD, ALUSEL_LOAD, ALUSEL_STORE};
  logic [31:0] v_addr [6] = '{32'h2001, 32'h0102, 32'h0005, 32'h2003, 32'h2002, 32'h0010};
  logic [31:0] v_od2  [6] = '{32'h11223344, 32'hAABBCCDD, 32'h11223344, 32'h99999999, 32'h0, 32'h12345678};
  logic        e_wr   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [1:0]  e_size [6] = '{2'd2, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0};
  logic [31:0] e_addr [6] = '{32'h2000, 32'h0102, 32'h0004, 32'h2000, 32'h2002, 32'h0010};
  logic [3:0]  e_strb [6] = '{4'b1110, 4'b1100, 4'b0011, 4'b0000, 4'b0000, 4'b0001};
  logic [31:0] e_wdat [6] = '{32'h22334400, 32'hCCDDCCDD, 32'h00001122, 32'h0, 32'h0, 32'h78787878};

  task automatic test_reset();
    rst = 1'b1; ex_valid = 1'b0; ex_pri = '0; ex_sec = '0;
    mem2_allowin = 1'b1; llbit_clear = 1'b0; dmem.addr_ok = 1'b0;
    step(); step();
    checks++;
    if ({dmem.req, dmem.wr, dmem.size, dmem.addr, dmem.wstrb, dmem.wdata} !== 72'd0) begin
      errors++; $display("FAIL reset_dmem got req=%0b wr=%0b addr=%h", dmem.req, dmem.wr, dmem.addr);
    end
    checks++;
    if (allowin_o !== 1'b1) begin errors++; $display("FAIL reset_allowin got %0b exp 1", allowin_o); end
    checks++;
    if ({valid_o, pri_o, sec_o, byp_o, id_o} !== '0) begin
      errors++; $display("FAIL reset_buses got valid=%0b pri=%h", valid_o, pri_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_sw();
    logic [PRI_W-1:0] p;
    p = mk_pri(SW_OP, ALUSEL_STORE, 32'h1004, 32'hDEADBEEF, 32'h0, 5'd7, 1'b0);
    step(); ex_valid = 1'b1; ex_pri = p; ex_sec = 70'h5; dmem.addr_ok = 1'b1; mem2_allowin = 1'b1;
    step(); ex_valid = 1'b0; #1;
    checks++;
    if ({dmem.req, dmem.wr, dmem.size, dmem.wstrb} !== {1'b1, 1'b1, 2'd2, 4'b1111}) begin
      errors++; $display("FAIL sw_ctrl got req=%0b wr=%0b size=%0d strb=%b", dmem.req, dmem.wr, dmem.size, dmem.wstrb);
    end
    checks++;
    if ({dmem.addr, dmem.wdata} !== {32'h1004, 32'hDEADBEEF}) begin
      errors++; $display("FAIL sw_addr_data got %h %h exp 00001004 deadbeef", dmem.addr, dmem.wdata);
    end
    checks++;
    if ({allowin_o, valid_o} !== 2'b11) begin
      errors++; $display("FAIL sw_advance got allowin=%0b valid=%0b exp 1 1", allowin_o, valid_o);
    end
    checks++;
    if (pri_o !== p) begin errors++; $display("FAIL sw_pri_pass got %h exp %h", pri_o, p); end
    checks++;
    if (id_o !== {1'b1, 5'd7, ALUSEL_STORE}) begin errors++; $display("FAIL sw_id_bus got %h", id_o); end
    step(); #1;
    checks++;
    if ({valid_o, dmem.req} !== 2'b00) begin
      errors++; $display("FAIL sw_drain got valid=%0b req=%0b exp 0 0", valid_o, dmem.req);
    end
  endtask

  task automatic test_sb_delay();
    step(); ex_valid = 1'b1; dmem.addr_ok = 1'b0;
    ex_pri = mk_pri(SB_OP, ALUSEL_STORE, 32'h1003, 32'h000000A5, 32'h0, 5'd0, 1'b0);
    step(); ex_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem.addr_ok = 1'b1;
      #1;
      checks++;
      if ({dmem.req, dmem.size, dmem.addr, dmem.wstrb, dmem.wdata} !== {1'b1, 2'd0, 32'h1003, 4'b1000, 32'hA5A5A5A5}) begin
        errors++; $display("FAIL sb_hold cyc%0d got req=%0b strb=%b wdata=%h", i, dmem.req, dmem.wstrb, dmem.wdata);
      end
      checks++;
      if ({allowin_o, valid_o} !== {i == 3, i == 3}) begin
        errors++; $display("FAIL sb_stall cyc%0d got allowin=%0b valid=%0b", i, allowin_o, valid_o);
      end
      step();
    end
    dmem.addr_ok = 1'b0; #1;
    checks++;
    if ({dmem.req, valid_o} !== 2'b00) begin errors++; $display("FAIL sb_after got req=%0b valid=%0b", dmem.req, valid_o); end
  endtask

  task automatic test_back_to_back();
    dmem.addr_ok = 1'b1; mem2_allowin = 1'b1;
    ex_valid = 1'b1; ex_pri = mk_pri(v_op[0], v_sel[0], v_addr[0], v_od2[0], 32'h0, 5'd1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      if (i < 5) ex_pri = mk_pri(v_op[i+1], v_sel[i+1], v_addr[i+1], v_od2[i+1], 32'h0, 5'd1, 1'b1);
      else ex_valid = 1'b0;
      #1;
      checks++;
      if ({dmem.req, dmem.wr, dmem.size, dmem.addr, dmem.wstrb, dmem.wdata, valid_o} !==
          {1'b1, e_wr[i], e_size[i], e_addr[i], e_strb[i], e_wdat[i], 1'b1}) begin
        errors++;
        $display("FAIL b2b_vec%0d got wr=%0b size=%0d addr=%h strb=%b wdata=%h exp %0b %0d %h %b %h",
                 i, dmem.wr, dmem.size, dmem.addr, dmem.wstrb, dmem.wdata,
                 e_wr[i], e_size[i], e_addr[i], e_strb[i], e_wdat[i]);
      end
    end
    step();
  endtask

  task automatic test_llsc();
    pri_bus_t po;
    logic     exp_req2;
    logic     exp_res2;
`ifdef MEM1_LLSC_EN
    exp_req2 = 1'b0; exp_res2 = 1'b0;
`else
    exp_req2 = 1'b1; exp_res2 = 1'b1;
`endif
    dmem.addr_ok = 1'b1; mem2_allowin = 1'b1;
    step(); ex_valid = 1'b1; ex_pri = mk_pri(LL_OP, ALUSEL_LOAD, 32'h3000, 32'h0, 32'h0, 5'd4, 1'b1);
    step(); ex_pri = mk_pri(SC_OP, ALUSEL_STORE, 32'h3004, 32'h55, 32'h12345678, 5'd2, 1'b1); #1;
    checks++;
    if ({dmem.req, dmem.wr, dmem.size, dmem.addr, dmem.wstrb} !== {1'b1, 1'b0, 2'd2, 32'h3000, 4'b0}) begin
      errors++; $display("FAIL ll_req got req=%0b wr=%0b addr=%h strb=%b", dmem.req, dmem.wr, dmem.addr, dmem.wstrb);
    end
    step(); ex_pri = mk_pri(SC_OP, ALUSEL_STORE, 32'h3008, 32'h66, 32'h12345678, 5'd2, 1'b1); #1;
    po = pri_o;
    checks++;
    if ({dmem.req, dmem.wr, dmem.addr, dmem.wdata} !== {1'b1, 1'b1, 32'h3004, 32'h55}) begin
      errors++; $display("FAIL sc1_req got req=%0b wr=%0b addr=%h wdata=%h", dmem.req, dmem.wr, dmem.addr, dmem.wdata);
    end
    checks++;
    if (po.reg_wdata !== 32'd1) begin errors++; $display("FAIL sc1_result got %h exp 1", po.reg_wdata); end
    step(); ex_valid = 1'b0; #1;
    po = pri_o;
    checks++;
    if (dmem.req !== exp_req2) begin errors++; $display("FAIL sc2_req got %0b exp %0b", dmem.req, exp_req2); end
    checks++;
    if (po.reg_wdata !== {31'b0, exp_res2}) begin errors++; $display("FAIL sc2_result got %h exp %0b", po.reg_wdata, exp_res2); end
    checks++;
    if ({valid_o, allowin_o} !== 2'b11) begin
      errors++; $display("FAIL sc2_advance got valid=%0b allowin=%0b exp 1 1", valid_o, allowin_o);
    end
    step();
  endtask

  task automatic test_stall();
    int pulses;
    pri_bus_t p;
    pulses = 0;
    p = mk_pri(LW_OP, ALUSEL_LOAD, 32'h4000, 32'h0, 32'hCAFEF00D, 5'd3, 1'b1);
    step(); ex_valid = 1'b1; ex_pri = p; ex_sec = {32'h01020304, 5'd9, 1'b1, 32'hBFC0_0104};
    dmem.addr_ok = 1'b1; mem2_allowin = 1'b0;
    step(); ex_valid = 1'b0; #1;
    pulses += int'(dmem.req);
    checks++;
    if ({dmem.req, allowin_o, valid_o} !== 3'b101) begin
      errors++; $display("FAIL stall_c0 got req=%0b allowin=%0b valid=%0b exp 1 0 1", dmem.req, allowin_o, valid_o);
    end
    checks++;
    if (byp_o !== {32'h01020304, 5'd9, 1'b1, 32'hCAFEF00D, 5'd3, 1'b1}) begin
      errors++; $display("FAIL stall_bypass got %h", byp_o);
    end
    step(); #1;
    pulses += int'(dmem.req);
    checks++;
    if ({dmem.req, allowin_o, valid_o} !== 3'b001) begin
      errors++; $display("FAIL stall_c1 got req=%0b allowin=%0b valid=%0b exp 0 0 1", dmem.req, allowin_o, valid_o);
    end
    step(); mem2_allowin = 1'b1; dmem.addr_ok = 1'b0; #1;
    pulses += int'(dmem.req);
    checks++;
    if ({dmem.req, allowin_o, valid_o} !== 3'b011) begin
      errors++; $display("FAIL stall_release got req=%0b allowin=%0b valid=%0b exp 0 1 1", dmem.req, allowin_o, valid_o);
    end
    checks++;
    if (pri_o !== p) begin errors++; $display("FAIL stall_pri got %h exp %h", pri_o, p); end
    step(); #1;
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL stall_drain got valid=%0b exp 0", valid_o); end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL stall_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_llclear();
    pri_bus_t po;
    logic     exp_sc;
`ifdef MEM1_LLSC_EN
    exp_sc = 1'b0;
`else
    exp_sc = 1'b1;
`endif
    dmem.addr_ok = 1'b1; mem2_allowin = 1'b1;
    step(); ex_valid = 1'b1; ex_pri = mk_pri(LL_OP, ALUSEL_LOAD, 32'h5000, 32'h0, 32'h0, 5'd4, 1'b1);
    step(); ex_valid = 1'b0;
    step(); llbit_clear = 1'b1;
    step(); llbit_clear = 1'b0; ex_valid = 1'b1;
    ex_pri = mk_pri(SC_OP, ALUSEL_STORE, 32'h5004, 32'h77, 32'hABCD, 5'd6, 1'b1);
    step(); ex_valid = 1'b0; #1;
    po = pri_o;
    checks++;
    if ({dmem.req, po.reg_wdata} !== {exp_sc, 31'b0, exp_sc}) begin
      errors++; $display("FAIL llclear_sc got req=%0b result=%h exp %0b", dmem.req, po.reg_wdata, exp_sc);
    end
    checks++;
    if (valid_o !== 1'b1) begin errors++; $display("FAIL llclear_valid got %0b exp 1", valid_o); end
    step();
  endtask

  task automatic test_reset_mid();
    dmem.addr_ok = 1'b0; mem2_allowin = 1'b1;
    step(); ex_valid = 1'b1; ex_pri = mk_pri(SW_OP, ALUSEL_STORE, 32'h6000, 32'h1, 32'h0, 5'd0, 1'b0);
    step(); ex_valid = 1'b0; #1;
    checks++;
    if (dmem.req !== 1'b1) begin errors++; $display("FAIL rstmid_pre got req=%0b exp 1", dmem.req); end
    rst = 1'b1;
    step(); rst = 1'b0; #1;
    checks++;
    if ({dmem.req, valid_o, allowin_o} !== 3'b001) begin
      errors++; $display("FAIL rstmid_drop got req=%0b valid=%0b allowin=%0b exp 0 0 1", dmem.req, valid_o, allowin_o);
    end
    step(); #1;
    checks++;
    if ({dmem.req, pri_o} !== '0) begin errors++; $display("FAIL rstmid_discard got req=%0b", dmem.req); end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb_delay();
    test_back_to_back();
    test_llsc();
    test_stall();
    test_llclear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
